// File: rtl/fluid_pkg.sv
// Shared types and constants for the double-buffered fluid-cell grid.
// A cell is nine lattice densities (bytes 0-8) plus a spare byte; byte 0 = WALL_MARK is a wall.
package fluid_pkg;

  localparam int unsigned CELL_BYTES = 10;
  localparam logic [7:0]  WALL_MARK  = 8'd255;

  typedef logic [CELL_BYTES-1:0][7:0] cell_t;

  typedef enum logic [1:0] {
    StInit,
    StFill,
    StDoneWait
  } state_e;

endpackage

// File: rtl/fluid_grid_buffer_if.sv
// Bus between the grid buffer, the physics engine and the display pixel calculator.
// The slave modport is the buffer side; master is the engine/display side.
interface fluid_grid_buffer_if
  import fluid_pkg::*;
#(
  parameter int unsigned AddrW = 15
);

  logic [AddrW-1:0] disp_addr_in;
  cell_t            disp_data_out;
  logic [AddrW-1:0] phys_addr_in;
  cell_t            phys_data_out;
  logic             wr_valid_in;
  cell_t            wr_data_in;
  logic             wr_ready_out;
  logic             new_frame_in;
  logic             swap_out;
  logic             front_bank_out;
  logic             init_busy_out;

  modport slave (
    input  disp_addr_in,
    output disp_data_out,
    input  phys_addr_in,
    output phys_data_out,
    input  wr_valid_in,
    input  wr_data_in,
    output wr_ready_out,
    input  new_frame_in,
    output swap_out,
    output front_bank_out,
    output init_busy_out
  );

  modport master (
    output disp_addr_in,
    input  disp_data_out,
    output phys_addr_in,
    input  phys_data_out,
    output wr_valid_in,
    output wr_data_in,
    input  wr_ready_out,
    output new_frame_in,
    input  swap_out,
    input  front_bank_out,
    input  init_busy_out
  );

endinterface

// File: rtl/fluid_bank_bram.sv
// One grid bank: single write port, two read ports, registered address and registered output,
// giving a fixed 2-cycle read latency. A port with re low leaves its output register untouched.
module fluid_bank_bram
  import fluid_pkg::*;
#(
  parameter int unsigned Depth = 19200,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  cell_t            wdata_i,
  input  logic             a_re_i,
  input  logic [AddrW-1:0] a_addr_i,
  output cell_t            a_data_o,
  input  logic             b_re_i,
  input  logic [AddrW-1:0] b_addr_i,
  output cell_t            b_data_o
);

  cell_t            mem_q [Depth];
  logic [AddrW-1:0] a_addr_q, b_addr_q;
  logic             a_re_q, b_re_q;
  cell_t            a_data_q, b_data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    a_addr_q <= a_addr_i;
    b_addr_q <= b_addr_i;
    a_re_q   <= a_re_i;
    b_re_q   <= b_re_i;
    if (a_re_q) begin
      a_data_q <= mem_q[a_addr_q];
    end
    if (b_re_q) begin
      b_data_q <= mem_q[b_addr_q];
    end
  end

  assign a_data_o = a_data_q;
  assign b_data_o = b_data_q;

endmodule

// File: rtl/fluid_grid_buffer.sv
// Double-buffered fluid grid: physics streams the next grid into the back bank while display and
// physics read the front bank; banks swap only on new_frame_in once the back grid is complete.
module fluid_grid_buffer
  import fluid_pkg::*;
#(
  parameter int unsigned HPIXELS = 160,
  parameter int unsigned VPIXELS = 120
) (
  input logic                pixel_clk_in,
  input logic                rst_in,
  fluid_grid_buffer_if.slave bus_io
);

  localparam int unsigned BRAM_DEPTH = HPIXELS * VPIXELS;
  localparam int unsigned BRAM_SIZE  = $clog2(BRAM_DEPTH);
  localparam logic [BRAM_SIZE-1:0] LastAddr = BRAM_SIZE'(BRAM_DEPTH - 1);

  state_e               state_q, state_d;
  logic [BRAM_SIZE-1:0] clr_q, clr_d;
  logic [BRAM_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic                 front_q, front_d;
  logic                 wr_ready, init_busy, swap, wr_accept;

  // FSM state register
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // A new_frame_in outside DONE_WAIT is dropped, so the display repeats the old grid.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:     if (clr_q == LastAddr) state_d = StFill;
      StFill:     if (wr_accept && (wr_addr_q == LastAddr)) state_d = StDoneWait;
      StDoneWait: if (bus_io.new_frame_in) state_d = StFill;
      default:    state_d = StInit;
    endcase
  end

  always_comb begin
    wr_ready  = 1'b0;
    init_busy = 1'b0;
    swap      = 1'b0;
    unique case (state_q)
      StInit:     init_busy = 1'b1;
      StFill:     wr_ready  = 1'b1;
      StDoneWait: swap      = bus_io.new_frame_in;
      default:    ;
    endcase
  end

  assign wr_accept = wr_ready & bus_io.wr_valid_in;

  always_comb begin
    clr_d     = clr_q;
    wr_addr_d = wr_addr_q;
    front_d   = front_q;
    if (init_busy) begin
      clr_d = (clr_q == LastAddr) ? '0 : clr_q + BRAM_SIZE'(1);
    end
    if (wr_accept) begin
      wr_addr_d = (wr_addr_q == LastAddr) ? '0 : wr_addr_q + BRAM_SIZE'(1);
    end
    if (swap) begin
      front_d = ~front_q;
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      clr_q     <= '0;
      wr_addr_q <= '0;
      front_q   <= 1'b0;
    end else begin
      clr_q     <= clr_d;
      wr_addr_q <= wr_addr_d;
      front_q   <= front_d;
    end
  end

  // Write steering: the post-reset clear hits both banks, stream beats hit only the back bank.
  logic [1:0]           bank_we;
  logic [BRAM_SIZE-1:0] bank_waddr;
  cell_t                bank_wdata;

  always_comb begin
    bank_we    = 2'b00;
    bank_waddr = wr_addr_q;
    bank_wdata = bus_io.wr_data_in;
    if (init_busy) begin
      bank_we    = 2'b11;
      bank_waddr = clr_q;
      bank_wdata = '0;
    end else if (wr_accept) begin
      bank_we[~front_q] = 1'b1;
    end
  end

  // Reads issued during the clear or out of range return zero without touching a bank.
  logic disp_zero, phys_zero;
  assign disp_zero = init_busy | (32'(bus_io.disp_addr_in) >= BRAM_DEPTH);
  assign phys_zero = init_busy | (32'(bus_io.phys_addr_in) >= BRAM_DEPTH);

  // Zero flags reset high so both outputs read zero for the two cycles after reset.
  logic [1:0] disp_zero_q, phys_zero_q, sel_q;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      disp_zero_q <= 2'b11;
      phys_zero_q <= 2'b11;
      sel_q       <= 2'b00;
    end else begin
      disp_zero_q <= {disp_zero_q[0], disp_zero};
      phys_zero_q <= {phys_zero_q[0], phys_zero};
      sel_q       <= {sel_q[0], front_q};
    end
  end

  cell_t disp_rd [2];
  cell_t phys_rd [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fluid_bank_bram #(
      .Depth (BRAM_DEPTH),
      .AddrW (BRAM_SIZE)
    ) u_bram (
      .clk_i    (pixel_clk_in),
      .we_i     (bank_we[b]),
      .waddr_i  (bank_waddr),
      .wdata_i  (bank_wdata),
      .a_re_i   (~disp_zero & (front_q == 1'(b))),
      .a_addr_i (bus_io.disp_addr_in),
      .a_data_o (disp_rd[b]),
      .b_re_i   (~phys_zero & (front_q == 1'(b))),
      .b_addr_i (bus_io.phys_addr_in),
      .b_data_o (phys_rd[b])
    );
  end

  assign bus_io.disp_data_out  = disp_zero_q[1] ? '0 : disp_rd[sel_q[1]];
  assign bus_io.phys_data_out  = phys_zero_q[1] ? '0 : phys_rd[sel_q[1]];
  assign bus_io.wr_ready_out   = wr_ready;
  assign bus_io.init_busy_out  = init_busy;
  assign bus_io.swap_out       = swap;
  assign bus_io.front_bank_out = front_q;

endmodule

// File: tb/tb_fluid_grid_buffer.sv
// Bench for fluid_grid_buffer on a reduced 20x6 grid: frame-level reference model checked every
// cycle, a table of read vectors, hand sequences for swap corner cases, then random traffic.
module tb_fluid_grid_buffer;
  import fluid_pkg::*;

  localparam int unsigned HP = 20;
  localparam int unsigned VP = 6;
  localparam int unsigned D  = HP * VP;
  localparam int unsigned AW = $clog2(D);
  localparam int          AMAX = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fluid_grid_buffer_if #(.AddrW(AW)) bus ();

  fluid_grid_buffer #(
    .HPIXELS (HP),
    .VPIXELS (VP)
  ) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .bus_io       (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: grid contents per bank, frame progress, expected read pipeline.
  cell_t m_bank [2][D];
  int    m_init_left, m_count, m_front;
  bit    m_full;
  cell_t exp_d [2];
  cell_t exp_p [2];

  logic  obs_busy, obs_ready, obs_swap, obs_front;
  cell_t obs_disp, obs_phys;

  typedef struct {
    logic [AW-1:0] da;
    logic [AW-1:0] pa;
    cell_t         ed;
    cell_t         ep;
  } rd_vec_t;
  rd_vec_t vt [5];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic cell_t mk_cell(input int k, input int salt);
    cell_t c;
    c[0] = 8'(k);
    for (int b = 1; b < 10; b++) c[b] = 8'(k * 7 + b * 13 + salt);
    return c;
  endfunction

  function automatic cell_t rand_cell();
    cell_t c;
    for (int b = 0; b < 10; b++) c[b] = 8'($urandom);
    if ($urandom_range(0, 7) == 0) c[0] = WALL_MARK;
    return c;
  endfunction

  function automatic cell_t model_read(input int addr);
    if (m_init_left > 0 || addr >= int'(D)) return '0;
    return m_bank[m_front][addr];
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < int'(D); i++) m_bank[b][i] = '0;
    m_init_left = int'(D);
    m_count     = 0;
    m_full      = 1'b0;
    m_front     = 0;
    exp_d[0] = '0; exp_d[1] = '0;
    exp_p[0] = '0; exp_p[1] = '0;
  endtask

  task automatic model_step();
    exp_d[0] = exp_d[1];
    exp_d[1] = model_read(int'(bus.disp_addr_in));
    exp_p[0] = exp_p[1];
    exp_p[1] = model_read(int'(bus.phys_addr_in));
    if (m_init_left > 0) begin
      m_init_left--;
    end else if (!m_full) begin
      if (bus.wr_valid_in) begin
        m_bank[1 - m_front][m_count] = bus.wr_data_in;
        m_count++;
        if (m_count == int'(D)) begin
          m_count = 0;
          m_full  = 1'b1;
        end
      end
    end else if (bus.new_frame_in) begin
      m_front = 1 - m_front;
      m_full  = 1'b0;
    end
  endtask

  // One clock: sample and check at negedge, advance the model, return just after posedge.
  task automatic cycle();
    @(negedge clk);
    obs_busy  = bus.init_busy_out;
    obs_ready = bus.wr_ready_out;
    obs_swap  = bus.swap_out;
    obs_front = bus.front_bank_out;
    obs_disp  = bus.disp_data_out;
    obs_phys  = bus.phys_data_out;
    if (!rst) begin
      chk("init_busy", 80'(obs_busy), 80'(m_init_left > 0));
      chk("wr_ready", 80'(obs_ready), 80'(m_init_left == 0 && !m_full));
      chk("swap", 80'(obs_swap), 80'(m_full && bus.new_frame_in));
      chk("front_bank", 80'(obs_front), 80'(m_front));
      chk("disp_data", obs_disp, exp_d[0]);
      chk("phys_data", obs_phys, exp_p[0]);
    end
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int busy_cnt, rise, swaps;

    vt[0] = '{AW'(3), AW'(7), mk_cell(3, 0), mk_cell(7, 0)};
    vt[1] = '{AW'(D + 7), AW'(D + 7), '0, '0};
    vt[2] = '{AW'(0), AW'(D - 1), mk_cell(0, 0), mk_cell(int'(D) - 1, 0)};
    vt[3] = '{AW'(D), AW'(50), '0, mk_cell(50, 0)};
    vt[4] = '{AW'(64), AW'(D - 1), mk_cell(64, 0), mk_cell(int'(D) - 1, 0)};

    bus.disp_addr_in = AW'(5);
    bus.phys_addr_in = AW'(5);
    bus.wr_valid_in  = 1'b0;
    bus.wr_data_in   = '0;
    bus.new_frame_in = 1'b0;
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;

    // Post-reset clear length and ready rise.
    busy_cnt = 0;
    rise = 0;
    for (int c = 1; c <= int'(D) + 10; c++) begin
      cycle();
      if (c <= 2) begin
        chk("post_reset_disp_zero", obs_disp, '0);
        chk("post_reset_phys_zero", obs_phys, '0);
      end
      if (obs_busy) busy_cnt++;
      if (obs_ready) begin
        rise = c;
        break;
      end
    end
    chk("init_length", 80'(busy_cnt), 80'(D));
    chk("ready_rise_cycle", 80'(rise), 80'(D + 1));

    // Frame 1 into bank 1, then swap.
    for (int k = 0; k < int'(D); k++) begin
      bus.wr_valid_in = 1'b1;
      bus.wr_data_in  = mk_cell(k, 0);
      cycle();
    end
    bus.wr_valid_in = 1'b0;
    cycle();
    chk("done_wait_ready_low", 80'(obs_ready), 80'(0));
    swaps = 0;
    bus.new_frame_in = 1'b1;
    cycle();
    if (obs_swap) swaps++;
    bus.new_frame_in = 1'b0;
    repeat (3) begin
      cycle();
      if (obs_swap) swaps++;
    end
    chk("swap_once", 80'(swaps), 80'(1));
    chk("front_after_swap", 80'(obs_front), 80'(1));

    for (int i = 0; i < 5; i++) begin
      bus.disp_addr_in = vt[i].da;
      bus.phys_addr_in = vt[i].pa;
      repeat (3) cycle();
      chk("table_disp", obs_disp, vt[i].ed);
      chk("table_phys", obs_phys, vt[i].ep);
    end

    // Frame 2 into bank 0 with a stray pulse mid-fill and a pulse on the last beat.
    for (int k = 0; k < 100; k++) begin
      bus.wr_valid_in = 1'b1;
      bus.wr_data_in  = mk_cell(k, 5);
      cycle();
    end
    bus.wr_valid_in  = 1'b0;
    bus.new_frame_in = 1'b1;
    cycle();
    chk("mid_fill_no_swap", 80'(obs_swap), 80'(0));
    chk("mid_fill_ready", 80'(obs_ready), 80'(1));
    bus.new_frame_in = 1'b0;
    cycle();
    chk("mid_fill_front_kept", 80'(obs_front), 80'(1));
    chk("mid_fill_ready_after", 80'(obs_ready), 80'(1));
    for (int k = 100; k < int'(D); k++) begin
      bus.wr_valid_in  = 1'b1;
      bus.wr_data_in   = mk_cell(k, 5);
      bus.new_frame_in = (k == int'(D) - 1);
      cycle();
      if (k == int'(D) - 1) chk("last_beat_no_swap", 80'(obs_swap), 80'(0));
    end
    bus.wr_valid_in  = 1'b0;
    bus.new_frame_in = 1'b0;
    cycle();
    chk("coincident_done_wait", 80'(obs_ready), 80'(0));
    chk("coincident_front_kept", 80'(obs_front), 80'(1));
    repeat (3) cycle();
    bus.new_frame_in = 1'b1;
    cycle();
    chk("late_swap", 80'(obs_swap), 80'(1));
    bus.new_frame_in = 1'b0;
    bus.disp_addr_in = AW'(3);
    bus.phys_addr_in = AW'(D - 1);
    repeat (3) cycle();
    chk("late_swap_front", 80'(obs_front), 80'(0));
    chk("frame2_disp", obs_disp, mk_cell(3, 5));
    chk("frame2_phys", obs_phys, mk_cell(int'(D) - 1, 5));

    // Frame 3 into bank 1, then reads every cycle across the swap.
    for (int k = 0; k < int'(D); k++) begin
      bus.wr_valid_in  = 1'b1;
      bus.wr_data_in   = mk_cell(k, 9);
      bus.disp_addr_in = AW'((k * 5) % int'(D));
      bus.phys_addr_in = AW'($urandom_range(0, AMAX));
      cycle();
    end
    bus.wr_valid_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.disp_addr_in = AW'((i * 11) % int'(D));
      bus.phys_addr_in = AW'((i * 17 + 3) % int'(D));
      bus.new_frame_in = (i == 3);
      cycle();
      if (i == 5) chk("swap_edge_old_bank", obs_disp, mk_cell(33, 5));
      if (i == 6) chk("swap_edge_new_bank", obs_disp, mk_cell(44, 9));
    end
    bus.new_frame_in = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      bus.wr_valid_in  = ($urandom_range(0, 3) != 0);
      bus.wr_data_in   = rand_cell();
      bus.disp_addr_in = AW'($urandom_range(0, AMAX));
      bus.phys_addr_in = AW'($urandom_range(0, AMAX));
      bus.new_frame_in = ($urandom_range(0, 19) == 0);
      cycle();
    end

    // Steer to front bank 1 part-way through a fill, then reset.
    for (int n = 0; n < 600; n++) begin
      if (m_front == 1 && !m_full && m_init_left == 0 && m_count >= 30) break;
      bus.wr_valid_in  = 1'b1;
      bus.wr_data_in   = rand_cell();
      bus.new_frame_in = 1'b1;
      cycle();
    end
    chk("pre_reset_front", 80'(obs_front), 80'(m_front));
    bus.wr_valid_in  = 1'b0;
    bus.new_frame_in = 1'b0;
    bus.disp_addr_in = AW'(3);
    bus.phys_addr_in = AW'(3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("reset_front_zero", 80'(obs_front), 80'(0));
    chk("reset_busy", 80'(obs_busy), 80'(1));
    chk("reset_ready_low", 80'(obs_ready), 80'(0));
    repeat (int'(D) + 4) cycle();
    chk("cleared_disp", obs_disp, '0);
    chk("cleared_phys", obs_phys, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
